// File: rtl/prog_loader_pkg.sv
// Shared definitions for the serial boot loader and the instruction memory it feeds.
package prog_loader_pkg;

  localparam int unsigned IMEM_AW = 8;
  localparam int unsigned IMEM_DW = 16;
  localparam int unsigned BYTE_W  = 8;

  localparam logic [BYTE_W-1:0] SYNC_BYTE_DEFAULT = 8'hA5;

  // Loader states; WRITE is the only state that refuses a byte.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COUNT,
    ST_HI,
    ST_LO,
    ST_WRITE,
    ST_CSUM,
    ST_DONE
  } state_e;

  // One imem write-port transaction.
  typedef struct packed {
    logic               wen;
    logic [IMEM_AW-1:0] addr;
    logic [IMEM_DW-1:0] data;
  } imem_wr_t;

endpackage

// File: rtl/prog_loader.sv
// Boot loader: unpacks a framed byte stream into 16-bit imem words and
// releases the cpu from reset only after a frame with a good checksum.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter logic [BYTE_W-1:0]  SYNC_BYTE = SYNC_BYTE_DEFAULT,
  parameter logic [IMEM_AW-1:0] BASE_ADDR = 8'h00,
  parameter int unsigned        TIMEOUT   = 65535
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rx_valid,
  input  logic [BYTE_W-1:0]  rx_data,
  output logic               rx_ready,
  output logic               im_wen,
  output logic [IMEM_AW-1:0] im_waddr,
  output logic [IMEM_DW-1:0] im_wdata,
  output logic               cpu_rst,
  output logic               done,
  output logic               err
);

  localparam int unsigned       TIMER_W      = $clog2(TIMEOUT + 1);
  localparam logic [TIMER_W-1:0] TIMEOUT_LAST = TIMER_W'(TIMEOUT - 1);

  state_e              state_q, state_d;
  logic [BYTE_W-1:0]   n_q, n_d;
  logic [IMEM_AW-1:0]  idx_q, idx_d;
  logic [BYTE_W-1:0]   sum_q, sum_d;
  logic [BYTE_W-1:0]   hi_q, hi_d;
  logic [TIMER_W-1:0]  timer_q, timer_d;
  imem_wr_t            wr_q, wr_d;
  logic                rx_ready_q, rx_ready_d;
  logic                cpu_rst_q, cpu_rst_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  logic accept;
  logic timed;
  logic timeout;

  // State and output registers; rst returns everything to the idle/held state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      n_q        <= '0;
      idx_q      <= '0;
      sum_q      <= '0;
      hi_q       <= '0;
      timer_q    <= '0;
      wr_q       <= '0;
      rx_ready_q <= 1'b1;
      cpu_rst_q  <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      idx_q      <= idx_d;
      sum_q      <= sum_d;
      hi_q       <= hi_d;
      timer_q    <= timer_d;
      wr_q       <= wr_d;
      rx_ready_q <= rx_ready_d;
      cpu_rst_q  <= cpu_rst_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  // Frame parser: next state, datapath updates and next registered outputs.
  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    idx_d     = idx_q;
    sum_d     = sum_q;
    hi_d      = hi_q;
    timer_d   = timer_q;
    wr_d      = wr_q;
    wr_d.wen  = 1'b0;
    cpu_rst_d = cpu_rst_q;
    done_d    = done_q;
    err_d     = err_q;

    accept  = rx_valid && rx_ready_q;
    timed   = (state_q == ST_COUNT) || (state_q == ST_HI) ||
              (state_q == ST_LO)    || (state_q == ST_CSUM);
    timeout = timed && (timer_q == TIMEOUT_LAST);

    // Idle timer only runs while a frame is waiting for its next byte.
    if (!timed || accept) begin
      timer_d = '0;
    end else begin
      timer_d = timer_q + TIMER_W'(1);
    end

    if (timeout) begin
      // Abort wins over a byte arriving in the same cycle.
      state_d   = ST_IDLE;
      err_d     = 1'b1;
      cpu_rst_d = 1'b1;
      done_d    = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept && (rx_data == SYNC_BYTE)) begin
            state_d = ST_COUNT;
            err_d   = 1'b0;
          end
        end
        ST_COUNT: begin
          if (accept) begin
            n_d     = rx_data;
            sum_d   = rx_data;
            idx_d   = '0;
            state_d = ST_HI;
          end
        end
        ST_HI: begin
          if (accept) begin
            hi_d    = rx_data;
            sum_d   = sum_q + rx_data;
            state_d = ST_LO;
          end
        end
        ST_LO: begin
          if (accept) begin
            sum_d     = sum_q + rx_data;
            wr_d.wen  = 1'b1;
            wr_d.addr = BASE_ADDR + idx_q;
            wr_d.data = {hi_q, rx_data};
            state_d   = ST_WRITE;
          end
        end
        ST_WRITE: begin
          // N of zero wraps to 8'hFF here, giving the 256-word frame.
          if (idx_q == IMEM_AW'(n_q - 8'd1)) begin
            state_d = ST_CSUM;
          end else begin
            idx_d   = idx_q + 8'd1;
            state_d = ST_HI;
          end
        end
        ST_CSUM: begin
          if (accept) begin
            if (rx_data == sum_q) begin
              state_d   = ST_DONE;
              done_d    = 1'b1;
              cpu_rst_d = 1'b0;
            end else begin
              state_d   = ST_IDLE;
              err_d     = 1'b1;
              cpu_rst_d = 1'b1;
            end
          end
        end
        ST_DONE: begin
          if (accept && (rx_data == SYNC_BYTE)) begin
            state_d   = ST_COUNT;
            cpu_rst_d = 1'b1;
            done_d    = 1'b0;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    rx_ready_d = (state_d != ST_WRITE);
  end

  assign rx_ready = rx_ready_q;
  assign im_wen   = wr_q.wen;
  assign im_waddr = wr_q.addr;
  assign im_wdata = wr_q.data;
  assign cpu_rst  = cpu_rst_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: frames are built from a word list, the expected imem
// writes and frame outcomes are queued, and independent monitors check them.
module tb_prog_loader;

  localparam logic [7:0] SYNC = 8'hA5;
  localparam logic [7:0] BASE = 8'h80;
  localparam int unsigned TO  = 40;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        im_wen;
  logic [7:0]  im_waddr;
  logic [15:0] im_wdata;
  logic        cpu_rst;
  logic        done;
  logic        err;

  prog_loader #(
    .SYNC_BYTE(SYNC),
    .BASE_ADDR(BASE),
    .TIMEOUT  (TO)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .rx_valid(rx_valid),
    .rx_data (rx_data),
    .rx_ready(rx_ready),
    .im_wen  (im_wen),
    .im_waddr(im_waddr),
    .im_wdata(im_wdata),
    .cpu_rst (cpu_rst),
    .done    (done),
    .err     (err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  addr;
    logic [15:0] data;
  } wr_exp_t;

  int          n_checks = 0;
  int          n_fail   = 0;
  wr_exp_t     wr_q[$];
  bit          outc_q[$];
  logic [15:0] words[256];
  logic        prev_done = 1'b0;
  logic        prev_err  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Offer one byte and hold it until the loader takes it.
  task automatic send_byte(input logic [7:0] b, input bit gap);
    int waitc = 0;
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    while (!rx_ready && waitc < 50) begin
      @(negedge clk);
      waitc++;
    end
    if (!rx_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL rx_ready_wait: got 0 expected 1 at %0t", $time);
      rx_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 rx_valid = 1'b0;
    if (gap) repeat ($urandom_range(0, 3)) @(negedge clk);
  endtask

  // Everything after SYNC: N, the words in words[], then the checksum.
  task automatic send_body(input int nw, input bit corrupt);
    logic [7:0] nb, sum, hi, lo, cs;
    nb  = 8'(nw);
    sum = nb;
    send_byte(nb, 1'b1);
    for (int i = 0; i < nw; i++) begin
      hi  = words[i][15:8];
      lo  = words[i][7:0];
      sum = sum + hi + lo;
      wr_q.push_back('{addr: 8'(BASE + 8'(i)), data: words[i]});
      send_byte(hi, 1'b1);
      send_byte(lo, 1'b1);
    end
    cs = corrupt ? (sum ^ 8'($urandom_range(1, 255))) : sum;
    outc_q.push_back(!corrupt);
    send_byte(cs, 1'b1);
  endtask

  task automatic send_frame(input int nw, input bit corrupt);
    send_byte(SYNC, 1'b1);
    send_body(nw, corrupt);
  endtask

  task automatic settle();
    repeat (4) @(negedge clk);
  endtask

  // Write monitor: every strobe must match the next queued word.
  always @(negedge clk) begin
    if (!rst && im_wen) begin
      if (wr_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: got %0h:%0h expected none at %0t", im_waddr, im_wdata, $time);
      end else begin
        wr_exp_t e;
        e = wr_q.pop_front();
        check("im_waddr", 32'(im_waddr), 32'(e.addr));
        check("im_wdata", 32'(im_wdata), 32'(e.data));
      end
    end
  end

  // Outcome monitor: a rising done or err closes the oldest pending frame.
  always @(negedge clk) begin
    if (!rst) begin
      if (done && !prev_done) begin
        if (outc_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_done: got 1 expected no outcome at %0t", $time);
        end else begin
          check("frame_outcome", 32'(1), 32'(outc_q.pop_front()));
        end
        check("cpu_rst_on_done", 32'(cpu_rst), 32'(0));
      end
      if (err && !prev_err) begin
        if (outc_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_err: got 1 expected no outcome at %0t", $time);
        end else begin
          check("frame_outcome", 32'(0), 32'(outc_q.pop_front()));
        end
        check("cpu_rst_on_err", 32'(cpu_rst), 32'(1));
        check("done_on_err", 32'(done), 32'(0));
      end
    end
    prev_done = done;
    prev_err  = err;
  end

  // Hang guard.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1, "watchdog expired");
  end

  task automatic check_reset_values(input string tag);
    check({tag, "_rx_ready"}, 32'(rx_ready), 32'(1));
    check({tag, "_cpu_rst"},  32'(cpu_rst),  32'(1));
    check({tag, "_done"},     32'(done),     32'(0));
    check({tag, "_err"},      32'(err),      32'(0));
    check({tag, "_im_wen"},   32'(im_wen),   32'(0));
    check({tag, "_im_waddr"}, 32'(im_waddr), 32'(0));
    check({tag, "_im_wdata"}, 32'(im_wdata), 32'(0));
  endtask

  initial begin
    rst      = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (3) @(posedge clk);
    #1 check_reset_values("reset");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_reset", 32'(rx_ready), 32'(1));

    // Single word frame.
    words[0] = 16'hF000;
    send_frame(1, 1'b0);
    settle();
    check("t1_done", 32'(done), 32'(1));
    check("t1_cpu_rst", 32'(cpu_rst), 32'(0));

    // Reload from DONE: SYNC re-asserts cpu reset at once; LDI r0,7 program.
    words[0] = 16'h5000;
    words[1] = 16'h0007;
    send_byte(SYNC, 1'b0);
    check("t2_sync_cpu_rst", 32'(cpu_rst), 32'(1));
    check("t2_sync_done", 32'(done), 32'(0));
    send_body(2, 1'b0);
    settle();
    check("t2_done", 32'(done), 32'(1));

    // Bad checksum: word still written, frame rejected.
    words[0] = 16'hF000;
    send_frame(1, 1'b1);
    settle();
    check("t3_err", 32'(err), 32'(1));
    check("t3_done", 32'(done), 32'(0));
    check("t3_cpu_rst", 32'(cpu_rst), 32'(1));
    check("t3_ready", 32'(rx_ready), 32'(1));

    // Junk before SYNC is dropped.
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    for (int i = 0; i < 3; i++) words[i] = 16'($urandom);
    send_frame(3, 1'b0);
    settle();
    check("t4_done", 32'(done), 32'(1));

    // Timeout after a lone hi byte, exactly TO cycles after the last accept.
    send_byte(SYNC, 1'b1);
    send_byte(8'h03, 1'b1);
    outc_q.push_back(1'b0);
    send_byte(8'h12, 1'b0);
    repeat (TO - 1) @(posedge clk);
    #1 check("t5_err_before", 32'(err), 32'(0));
    @(posedge clk);
    #1 check("t5_err_at", 32'(err), 32'(1));
    check("t5_cpu_rst", 32'(cpu_rst), 32'(1));
    check("t5_done", 32'(done), 32'(0));
    send_byte(SYNC, 1'b0);
    check("t5_sync_clears_err", 32'(err), 32'(0));
    words[0] = 16'hBEEF;
    words[1] = 16'h1234;
    send_body(2, 1'b0);
    settle();

    // Random frames with occasional junk and bad checksums.
    for (int f = 0; f < 12; f++) begin
      int nw;
      bit bad;
      nw  = $urandom_range(1, 8);
      bad = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < nw; i++) words[i] = 16'($urandom);
      if ($urandom_range(0, 2) == 0) begin
        logic [7:0] j;
        j = 8'($urandom);
        if (j == SYNC) j = j ^ 8'h01;
        send_byte(j, 1'b1);
      end
      send_frame(nw, bad);
      settle();
      check("rand_done", 32'(done), 32'(!bad));
      check("rand_err", 32'(err), 32'(bad));
    end

    // N=0 means 256 words; addresses wrap past FF.
    for (int i = 0; i < 256; i++) words[i] = 16'($urandom);
    send_frame(256, 1'b0);
    settle();
    check("t6_done", 32'(done), 32'(1));

    // Reset mid-frame after one word has been written.
    for (int i = 0; i < 4; i++) words[i] = 16'($urandom);
    send_byte(SYNC, 1'b1);
    send_byte(8'h04, 1'b1);
    wr_q.push_back('{addr: BASE, data: words[0]});
    send_byte(words[0][15:8], 1'b1);
    send_byte(words[0][7:0], 1'b1);
    send_byte(words[1][15:8], 1'b1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 check_reset_values("midrst");
    @(negedge clk);
    rst = 1'b0;
    words[0] = 16'hCAFE;
    words[1] = 16'h0BAD;
    send_frame(2, 1'b0);
    settle();
    check("recover_done", 32'(done), 32'(1));

    repeat (10) @(negedge clk);
    check("writes_pending", 32'(wr_q.size()), 32'(0));
    check("outcomes_pending", 32'(outc_q.size()), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
